// File: rtl/data_ram_ctrl.sv
// Byte-addressed word-wide data memory with lane strobes, alignment/range errors and req/done handshake.
// Latency: done/err/dout valid in the cycle after edge accept+WAIT_STATES+1; one request per WAIT_STATES+2 cycles.
// Backpressure: ready is low from accept until the done cycle; req seen while ready=0 is dropped, not queued.
module data_ram_ctrl #(
    parameter int DWIDTH      = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int DEPTH_BYTES = 65536,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DWIDTH-1:0]     din,
    input  logic [DWIDTH/8-1:0]   be,
    output logic                  ready,
    output logic                  done,
    output logic                  err,
    output logic [DWIDTH-1:0]     dout
);

    localparam int NB    = DWIDTH / 8;
    localparam int LSB   = $clog2(NB);
    localparam int WORDS = DEPTH_BYTES / NB;
    localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    logic [1:0]            state;
    logic [3:0]            cnt;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DWIDTH-1:0]     din_q;
    logic [NB-1:0]         be_q;

    // Storage is word-organised; aligned accesses map each word onto NB consecutive little-endian bytes.
    logic [DWIDTH-1:0] mem [WORDS];

    logic                  accept;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  bad;
    logic [ADDR_WIDTH:0]   end_addr;
    logic [WW-1:0]         widx;

    assign accept       = (state == S_IDLE) && ready && req;
    assign misaligned   = (addr_q & ADDR_WIDTH'(NB - 1)) != '0;
    assign end_addr     = {1'b0, addr_q} + (ADDR_WIDTH + 1)'(NB);
    assign out_of_range = end_addr > (ADDR_WIDTH + 1)'(DEPTH_BYTES);
    assign bad          = misaligned || out_of_range;
    assign widx         = WW'(addr_q >> LSB);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            ready  <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            dout   <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
            be_q   <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        we_q   <= we;
                        addr_q <= addr;
                        din_q  <= din;
                        be_q   <= be;
                        ready  <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            state <= S_ACCESS;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= 4'(WAIT_STATES);
                        end
                    end else begin
                        ready <= 1'b1;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                    done  <= 1'b1;
                    err   <= bad;
                    if (!bad && !we_q) begin
                        dout <= mem[widx];
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Contents survive reset; rst_n only blocks a commit that is in flight at the reset edge.
    always_ff @(posedge clk) begin
        if (rst_n && state == S_ACCESS && we_q && !bad) begin
            for (int i = 0; i < NB; i++) begin
                if (be_q[i]) begin
                    mem[widx][8*i +: 8] <= din_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Bench for data_ram_ctrl: a 16-bit/1-wait instance and a 32-bit/0-wait instance against a byte-array model.
module tb_data_ram_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req0, we0, ready0, done0, err0;
    logic [15:0] addr0, din0, dout0;
    logic [1:0]  be0;

    logic        req1, we1, ready1, done1, err1;
    logic [15:0] addr1;
    logic [31:0] din1, dout1;
    logic [3:0]  be1;

    data_ram_ctrl #(.DWIDTH(16), .ADDR_WIDTH(16), .DEPTH_BYTES(256), .WAIT_STATES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .addr(addr0), .din(din0), .be(be0),
        .ready(ready0), .done(done0), .err(err0), .dout(dout0)
    );

    data_ram_ctrl #(.DWIDTH(32), .ADDR_WIDTH(16), .DEPTH_BYTES(256), .WAIT_STATES(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .we(we1), .addr(addr1), .din(din1), .be(be1),
        .ready(ready1), .done(done1), .err(err1), .dout(dout1)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0]  m0 [256];
    logic [7:0]  m1 [256];
    logic [31:0] exp_d0 = '0;
    logic [31:0] exp_d1 = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic get_ready(input int sel);
        return (sel == 1) ? ready1 : ready0;
    endfunction
    function automatic logic get_done(input int sel);
        return (sel == 1) ? done1 : done0;
    endfunction
    function automatic logic get_err(input int sel);
        return (sel == 1) ? err1 : err0;
    endfunction
    function automatic logic [31:0] get_dout(input int sel);
        return (sel == 1) ? dout1 : {16'h0, dout0};
    endfunction

    function automatic logic [31:0] model_rd(input int sel, input int a);
        logic [31:0] v = '0;
        int nb = (sel == 1) ? 4 : 2;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = (sel == 1) ? m1[a+i] : m0[a+i];
        return v;
    endfunction

    task automatic drive(input int sel, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        if (sel == 1) begin
            req1 = r; we1 = w; addr1 = a[15:0]; din1 = d; be1 = b;
        end else begin
            req0 = r; we0 = w; addr0 = a[15:0]; din0 = d[15:0]; be0 = b[1:0];
        end
    endtask

    // One request, called at a negedge; returns at the negedge inside the done cycle.
    task automatic access(input int sel, input logic w, input int a, input logic [31:0] d,
                          input logic [3:0] b, input bit pulse);
        int nb, ws, n;
        logic e;
        nb = (sel == 1) ? 4 : 2;
        ws = (sel == 1) ? 0 : 1;
        drive(sel, 1'b1, w, a, d, b);
        n = 0;
        while (!get_ready(sel) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!get_ready(sel)) begin
            chk($sformatf("d%0d_ready_timeout", sel), 0, 1);
            drive(sel, 1'b0, 1'b0, 0, 0, 4'h0);
            return;
        end
        @(negedge clk);
        // Inputs change after accept; a pulse here must be ignored since ready is low.
        drive(sel, pulse, 1'($urandom), $urandom, $urandom, 4'($urandom));
        e = (a % nb != 0) || (a + nb > 256);
        if (!e) begin
            if (w) begin
                for (int i = 0; i < nb; i++) begin
                    if (b[i]) begin
                        if (sel == 1) m1[a+i] = d[8*i +: 8];
                        else          m0[a+i] = d[8*i +: 8];
                    end
                end
            end else if (sel == 1) begin
                exp_d1 = model_rd(1, a);
            end else begin
                exp_d0 = model_rd(0, a);
            end
        end
        for (int k = 0; k <= ws + 1; k++) begin
            if (k > 0) @(negedge clk);
            if (pulse && k == 1) begin
                if (sel == 1) req1 = 1'b0; else req0 = 1'b0;
            end
            chk($sformatf("d%0d_done_k%0d a=%0h", sel, k, a), get_done(sel), (k == ws + 1));
            chk($sformatf("d%0d_ready_k%0d a=%0h", sel, k, a), get_ready(sel), (k == ws + 1));
        end
        chk($sformatf("d%0d_err a=%0h we=%0b", sel, a, w), get_err(sel), e);
        chk($sformatf("d%0d_dout a=%0h we=%0b", sel, a, w), get_dout(sel),
            (sel == 1) ? exp_d1 : {16'h0, exp_d0[15:0]});
    endtask

    task automatic reset_mid(input int sel, input int a, input logic [31:0] d);
        logic [31:0] prior;
        int ws;
        ws = (sel == 1) ? 0 : 1;
        prior = model_rd(sel, a);
        drive(sel, 1'b1, 1'b1, a, d, 4'hF);
        chk($sformatf("d%0d_rm_ready", sel), get_ready(sel), 1'b1);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 0, 0, 4'h0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_d0 = '0;
        exp_d1 = '0;
        chk($sformatf("d%0d_rm_done_in_rst", sel), get_done(sel), 1'b0);
        chk($sformatf("d%0d_rm_dout_in_rst", sel), get_dout(sel), 32'h0);
        repeat (ws + 4) begin
            @(negedge clk);
            chk($sformatf("d%0d_rm_no_done", sel), get_done(sel), 1'b0);
        end
        access(sel, 1'b0, a, 0, 4'h0, 1'b0);
        chk($sformatf("d%0d_rm_prior", sel), get_dout(sel), prior);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] prior;
        int last, cnt, cyc, a;

        // Reset with req held high
        drive(0, 1'b1, 1'b0, 0, 0, 4'h0);
        drive(1, 1'b1, 1'b0, 0, 0, 4'h0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_ready0", ready0, 1'b0);
            chk("rst_done0", done0, 1'b0);
            chk("rst_dout0", dout0, 16'h0);
            chk("rst_ready1", ready1, 1'b0);
            chk("rst_done1", done1, 1'b0);
            chk("rst_dout1", dout1, 32'h0);
        end
        rst_n = 1'b1;
        drive(0, 1'b0, 1'b0, 0, 0, 4'h0);
        drive(1, 1'b0, 1'b0, 0, 0, 4'h0);
        @(negedge clk);
        chk("rel_ready0", ready0, 1'b1);
        chk("rel_ready1", ready1, 1'b1);
        repeat (4) begin
            @(negedge clk);
            chk("rel_no_done0", done0, 1'b0);
            chk("rel_no_done1", done1, 1'b0);
        end

        // Give every byte a known value
        for (int i = 0; i < 256; i += 2) access(0, 1'b1, i, $urandom, 4'h3, 1'b0);
        for (int i = 0; i < 256; i += 4) access(1, 1'b1, i, $urandom, 4'hF, 1'b0);

        // Write/read, byte lanes, errors
        access(0, 1'b1, 'h10, 32'hBEEF, 4'h3, 1'b0);
        access(0, 1'b0, 'h10, 0, 4'h0, 1'b0);
        chk("rd_beef", dout0, 16'hBEEF);
        access(0, 1'b1, 'h10, 32'h1234, 4'h1, 1'b0);
        access(0, 1'b0, 'h10, 0, 4'h0, 1'b0);
        chk("rd_be34", dout0, 16'hBE34);
        access(0, 1'b1, 'h10, 32'h5600, 4'h2, 1'b0);
        access(0, 1'b0, 'h10, 0, 4'h0, 1'b0);
        chk("rd_5634", dout0, 16'h5634);
        access(0, 1'b0, 'h11, 0, 4'h0, 1'b0);
        chk("misalign_err", err0, 1'b1);
        chk("misalign_hold", dout0, 16'h5634);
        prior = model_rd(0, 'hFE);
        access(0, 1'b1, 'hFF, 32'hDEAD, 4'h3, 1'b0);
        access(0, 1'b1, 'h100, 32'hDEAD, 4'h3, 1'b0);
        chk("oor_err", err0, 1'b1);
        access(0, 1'b0, 'hFE, 0, 4'h0, 1'b0);
        chk("last_word_ok", err0, 1'b0);
        chk("last_word_unchanged", dout0, prior);
        access(0, 1'b1, 'h10, 32'hFFFF, 4'h0, 1'b0);
        access(0, 1'b0, 'h10, 0, 4'h0, 1'b0);
        chk("be0_noop", dout0, 16'h5634);
        access(1, 1'b1, 'hFC, 32'h0, 4'hF, 1'b0);
        access(1, 1'b1, 'h102, 32'h0, 4'hF, 1'b0);
        access(1, 1'b1, 'h08, 32'hCAFEF00D, 4'hA, 1'b0);
        access(1, 1'b0, 'h08, 0, 4'h0, 1'b0);

        // Back-to-back reads with req held high
        drive(0, 1'b1, 1'b0, 0, 0, 4'h0);
        last = -1; cnt = 0; cyc = 0; a = 0;
        while (cnt < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done0) begin
                exp_d0 = model_rd(0, a);
                chk("b2b_err", err0, 1'b0);
                chk("b2b_dout", dout0, exp_d0[15:0]);
                if (last >= 0) chk("b2b_gap", cyc - last, 3);
                last = cyc;
                cnt++;
                a += 2;
                if (cnt < 4) addr0 = a[15:0]; else req0 = 1'b0;
            end
        end
        chk("b2b_count", cnt, 4);
        req0 = 1'b0;

        // req pulsed while busy is dropped
        access(0, 1'b0, 'h10, 0, 4'h0, 1'b1);
        repeat (6) begin
            @(negedge clk);
            chk("ignored_req_no_done", done0, 1'b0);
        end

        // Reset mid-operation
        reset_mid(0, 'h20, 32'hAAAA);
        reset_mid(1, 'h20, 32'hAAAAAAAA);

        // Random traffic
        repeat (300) begin
            int s, ra;
            s = $urandom_range(0, 1);
            ra = $urandom_range(0, 67) * 4 + (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            access(s, 1'($urandom), ra, $urandom, 4'($urandom), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
